// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encodings and the default hold limit.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0   = 2'd1;
  localparam logic [1:0] ST_G1   = 2'd2;

  localparam int unsigned MAX_HOLD_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StG0   = ST_G0,
    StG1   = ST_G1
  } arb_state_e;

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating hold counter: clears on clr, counts on en, stops at LIMIT.
module arb_hold_cnt #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CNT_W'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/arb2_rr.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux.
// Define ARB_TIMEOUT_EN to preempt an owner that holds the grant MAX_HOLD cycles.
module arb2_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       preempt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> CNT_W) != 0) begin : g_bad_cfg
    $error("arb2_rr: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       preempt_q, preempt_d;
  logic       at_limit;

`ifdef ARB_TIMEOUT_EN
  logic cnt_clr, cnt_en;

  // Restart on every grant entry (including a preemption), count while the owner stays.
  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q == StG0 || state_q == StG1) && (state_d == state_q);

  arb_hold_cnt #(
    .CNT_W(CNT_W),
    .LIMIT(MAX_HOLD - 1)
  ) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .at_limit(at_limit)
  );
`else
  assign at_limit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    preempt_d = 1'b0;
    case (state_q)
      StIdle: begin
        unique case (req)
          2'b01:   state_d = StG0;
          2'b10:   state_d = StG1;
          2'b11:   state_d = last_q ? StG0 : StG1;
          default: state_d = StIdle;
        endcase
      end
      StG0: begin
        if (!req[0]) begin
          state_d = req[1] ? StG1 : StIdle;
        end else if (req[1] && at_limit) begin
          state_d   = StG1;
          preempt_d = 1'b1;
        end
      end
      StG1: begin
        if (!req[1]) begin
          state_d = req[0] ? StG0 : StIdle;
        end else if (req[0] && at_limit) begin
          state_d   = StG0;
          preempt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    gnt_d  = 2'b00;
    sel_d  = sel_q;
    last_d = last_q;
    case (state_d)
      StG0: begin
        gnt_d  = 2'b01;
        sel_d  = 1'b0;
        last_d = 1'b0;
      end
      StG1: begin
        gnt_d  = 2'b10;
        sel_d  = 1'b1;
        last_d = 1'b1;
      end
      default: gnt_d = 2'b00;
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;

endmodule
